// File: rtl/riscv_instr_mem_arbiter_if.sv
// Bundles the requester, memory and status signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface riscv_instr_mem_arbiter_if #(
  parameter int RDATA_WIDTH = 32
);
  logic                   p0_req_i;
  logic [31:0]            p0_addr_i;
  logic                   p0_gnt_o;
  logic                   p0_rvalid_o;
  logic                   p0_err_pmp_o;
  logic                   p1_req_i;
  logic [31:0]            p1_addr_i;
  logic                   p1_gnt_o;
  logic                   p1_rvalid_o;
  logic                   p1_err_pmp_o;
  logic [RDATA_WIDTH-1:0] rdata_o;
  logic                   instr_req_o;
  logic [31:0]            instr_addr_o;
  logic                   instr_gnt_i;
  logic [RDATA_WIDTH-1:0] instr_rdata_i;
  logic                   instr_rvalid_i;
  logic                   instr_err_pmp_i;
  logic                   busy_o;
  logic                   proto_err_o;

  modport slave (
    input  p0_req_i, p0_addr_i, p1_req_i, p1_addr_i,
    input  instr_gnt_i, instr_rdata_i, instr_rvalid_i, instr_err_pmp_i,
    output p0_gnt_o, p0_rvalid_o, p0_err_pmp_o,
    output p1_gnt_o, p1_rvalid_o, p1_err_pmp_o,
    output rdata_o, instr_req_o, instr_addr_o, busy_o, proto_err_o
  );

  modport master (
    output p0_req_i, p0_addr_i, p1_req_i, p1_addr_i,
    output instr_gnt_i, instr_rdata_i, instr_rvalid_i, instr_err_pmp_i,
    input  p0_gnt_o, p0_rvalid_o, p0_err_pmp_o,
    input  p1_gnt_o, p1_rvalid_o, p1_err_pmp_o,
    input  rdata_o, instr_req_o, instr_addr_o, busy_o, proto_err_o
  );
endinterface

// File: rtl/riscv_instr_mem_arbiter.sv
// Two-port req/gnt/rvalid arbiter for the instruction memory: port 0 has priority, port 1
// has a starvation guard; an owner FIFO steers in-order responses back with zero latency.
module riscv_instr_mem_arbiter #(
  parameter int RDATA_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  riscv_instr_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                lock_addr_q, lock_addr_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [ST_W-1:0]            starve_q, starve_d;
  logic                       proto_err_q, proto_err_d;

  logic                   sel_vld;
  logic                   sel_owner;
  logic [31:0]            sel_addr;
  logic                   full;
  logic                   req;
  logic                   gnt_fire;
  logic                   push;
  logic                   pop;
  logic                   head_owner;
  logic [RDATA_WIDTH-1:0] rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A locked state keeps presenting the frozen owner/address until memory grants it.
  always_comb begin
    sel_vld   = 1'b0;
    sel_owner = 1'b0;
    sel_addr  = '0;
    case (state_q)
      LOCK0: begin
        sel_vld  = 1'b1;
        sel_addr = lock_addr_q;
      end
      LOCK1: begin
        sel_vld   = 1'b1;
        sel_owner = 1'b1;
        sel_addr  = lock_addr_q;
      end
      default: begin
        if (bus.p1_req_i && (starve_q == ST_W'(STARVE_LIMIT) || !bus.p0_req_i)) begin
          sel_vld   = 1'b1;
          sel_owner = 1'b1;
          sel_addr  = bus.p1_addr_i;
        end else if (bus.p0_req_i) begin
          sel_vld  = 1'b1;
          sel_addr = bus.p0_addr_i;
        end
      end
    endcase
  end

  // Full is judged on the registered count, so a same-cycle pop does not reopen the port.
  assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign req        = sel_vld & ~full;
  assign gnt_fire   = bus.instr_gnt_i & req;
  assign push       = gnt_fire & ~bus.instr_err_pmp_i;
  assign pop        = bus.instr_rvalid_i & (count_q != '0);
  assign head_owner = fifo_q[rd_ptr_q];
  assign rdata      = bus.instr_rdata_i;

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = sel_addr;
  assign bus.p0_gnt_o     = gnt_fire & ~sel_owner;
  assign bus.p1_gnt_o     = gnt_fire & sel_owner;
  assign bus.p0_err_pmp_o = bus.instr_err_pmp_i & bus.p0_gnt_o;
  assign bus.p1_err_pmp_o = bus.instr_err_pmp_i & bus.p1_gnt_o;
  assign bus.p0_rvalid_o  = pop & ~head_owner;
  assign bus.p1_rvalid_o  = pop & head_owner;
  assign bus.rdata_o      = rdata;
  assign bus.busy_o       = (count_q != '0) | req;
  assign bus.proto_err_o  = proto_err_q;

  always_comb begin
    state_d     = state_q;
    lock_addr_d = lock_addr_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    starve_d    = starve_q;
    proto_err_d = proto_err_q | (bus.instr_rvalid_i & (count_q == '0));

    case (state_q)
      LOCK0, LOCK1: if (bus.instr_gnt_i) state_d = ARB;
      default: begin
        if (req && !bus.instr_gnt_i) begin
          state_d     = sel_owner ? LOCK1 : LOCK0;
          lock_addr_d = sel_addr;
        end
      end
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = sel_owner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.p1_req_i && !bus.p1_gnt_o) begin
      starve_d = (starve_q == ST_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      lock_addr_q <= '0;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_addr_q <= lock_addr_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_riscv_instr_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each cycle's memory-side request and
// grants plus the in-order response stream; a negedge monitor compares against the DUT.
module tb_riscv_instr_mem_arbiter;
  localparam int MAXO = 2;
  localparam int LIM  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_instr_mem_arbiter_if #(.RDATA_WIDTH(32)) bus ();

  riscv_instr_mem_arbiter #(
    .RDATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    bit        req;
    bit [31:0] addr;
    bit        g0, g1, e0, e1, busy, perr;
  } cyc_t;

  typedef struct {
    bit        port;
    bit [31:0] data;
  } rsp_t;

  cyc_t      cyc_q[$];
  rsp_t      rsp_q[$];
  bit [31:0] mem_q[$];

  int        lock_own;
  bit [31:0] lock_addr;
  int        starve;
  bit        perr_m;

  int n_cmp = 0;
  int n_bad = 0;

  bit        dg0, dg1;
  bit        p0p, p1p;
  bit [31:0] p0a, p1a;
  cyc_t      mc;
  rsp_t      mr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.p0_req_i        = 1'b0;
    bus.p0_addr_i       = '0;
    bus.p1_req_i        = 1'b0;
    bus.p1_addr_i       = '0;
    bus.instr_gnt_i     = 1'b0;
    bus.instr_rdata_i   = '0;
    bus.instr_rvalid_i  = 1'b0;
    bus.instr_err_pmp_i = 1'b0;
  endtask

  task automatic model_clear();
    mem_q.delete();
    rsp_q.delete();
    cyc_q.delete();
    lock_own = -1;
    lock_addr = '0;
    starve = 0;
    perr_m = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p0_gnt"},  bus.p0_gnt_o, 0);
    check({tag, "_p0_rv"},   bus.p0_rvalid_o, 0);
    check({tag, "_p0_err"},  bus.p0_err_pmp_o, 0);
    check({tag, "_p1_gnt"},  bus.p1_gnt_o, 0);
    check({tag, "_p1_rv"},   bus.p1_rvalid_o, 0);
    check({tag, "_p1_err"},  bus.p1_err_pmp_o, 0);
    check({tag, "_rdata"},   bus.rdata_o, 0);
    check({tag, "_req"},     bus.instr_req_o, 0);
    check({tag, "_addr"},    bus.instr_addr_o, 0);
    check({tag, "_busy"},    bus.busy_o, 0);
    check({tag, "_perr"},    bus.proto_err_o, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    #3;
    check_all_zero({tag, "_in"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    check_all_zero({tag, "_out"});
  endtask

  // One clock of stimulus; the model predicts outputs from the ports' rules and queues them.
  task automatic step(input bit r0, input bit [31:0] a0, input bit r1, input bit [31:0] a1,
                      input bit g, input bit e, input bit rv, input bit [31:0] gd,
                      output bit g0o, output bit g1o);
    cyc_t      c;
    rsp_t      r;
    int        outst;
    int        own;
    bit        sel;
    bit [31:0] addr;
    bit        req;
    bit        fire;
    @(posedge clk);
    #1;
    outst = mem_q.size();
    bus.p0_req_i        = r0;
    bus.p0_addr_i       = a0;
    bus.p1_req_i        = r1;
    bus.p1_addr_i       = a1;
    bus.instr_gnt_i     = g;
    bus.instr_err_pmp_i = e;
    bus.instr_rvalid_i  = rv;
    bus.instr_rdata_i   = (rv && outst > 0) ? mem_q[0] : $urandom;

    own = 0; sel = 1'b0; addr = '0;
    if (lock_own >= 0) begin
      own = lock_own; sel = 1'b1; addr = lock_addr;
    end else if (r1 && (starve == LIM || !r0)) begin
      own = 1; sel = 1'b1; addr = a1;
    end else if (r0) begin
      own = 0; sel = 1'b1; addr = a0;
    end
    req  = sel && (outst < MAXO);
    fire = req && g;

    c.req  = req;
    c.addr = addr;
    c.g0   = fire && own == 0;
    c.g1   = fire && own == 1;
    c.e0   = c.g0 && e;
    c.e1   = c.g1 && e;
    c.busy = (outst > 0) || req;
    c.perr = perr_m;
    cyc_q.push_back(c);

    if (rv && outst == 0) perr_m = 1'b1;
    if (rv && outst > 0) void'(mem_q.pop_front());
    if (fire && !e) begin
      mem_q.push_back(gd);
      r.port = (own == 1);
      r.data = gd;
      rsp_q.push_back(r);
    end
    if (r1 && !c.g1) starve = (starve >= LIM) ? LIM : starve + 1;
    else starve = 0;
    if (lock_own >= 0) begin
      if (g) lock_own = -1;
    end else if (req && !g) begin
      lock_own = own;
      lock_addr = addr;
    end
    g0o = c.g0;
    g1o = c.g1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 1, 0, mem_q.size() > 0, $urandom, dg0, dg1);
    end
  endtask

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      check("instr_req",  bus.instr_req_o, mc.req);
      check("instr_addr", bus.instr_addr_o, mc.addr);
      check("p0_gnt",     bus.p0_gnt_o, mc.g0);
      check("p1_gnt",     bus.p1_gnt_o, mc.g1);
      check("p0_err_pmp", bus.p0_err_pmp_o, mc.e0);
      check("p1_err_pmp", bus.p1_err_pmp_o, mc.e1);
      check("busy",       bus.busy_o, mc.busy);
      check("proto_err",  bus.proto_err_o, mc.perr);
    end
    if (bus.p0_rvalid_o || bus.p1_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_unexpected: got p0=%0b p1=%0b, expected none (t=%0t)",
                 bus.p0_rvalid_o, bus.p1_rvalid_o, $time);
      end else begin
        mr = rsp_q.pop_front();
        check("rvalid_both", bus.p0_rvalid_o & bus.p1_rvalid_o, 0);
        check("rvalid_port", bus.p1_rvalid_o, mr.port);
        check("rdata",       bus.rdata_o, mr.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_clear();
    apply_reset("reset");

    // Both ports hammer with memory always granting: port 1 wins on the 9th cycle only.
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h1000, 1, 32'h2000, 1, 0, mem_q.size() > 0, $urandom, dg0, dg1);
      #3;
      check("arb_p1_gnt", bus.p1_gnt_o, (i == 8));
    end
    drain();

    // Port 1 locked at 0x100 while memory stalls; port 0 joins in cycle 2.
    step(0, 0, 1, 32'h100, 0, 0, 0, $urandom, dg0, dg1);
    step(1, 32'h40, 1, 32'h100, 0, 0, 0, $urandom, dg0, dg1);
    step(1, 32'h40, 1, 32'h100, 0, 0, 0, $urandom, dg0, dg1);
    #3;
    check("lock_addr", bus.instr_addr_o, 32'h100);
    step(1, 32'h40, 1, 32'h100, 1, 0, 0, $urandom, dg0, dg1);
    step(1, 32'h40, 0, 0, 1, 0, 0, $urandom, dg0, dg1);
    #3;
    check("lock_p0_after", bus.p0_gnt_o, 1);
    drain();

    // Response routing: P0 then P1 granted, data 0xA then 0xB come back in order.
    step(1, 32'h0, 0, 0, 1, 0, 0, 32'hA, dg0, dg1);
    step(0, 0, 1, 32'h200, 1, 0, 0, 32'hB, dg0, dg1);
    step(0, 0, 0, 0, 0, 0, 1, 0, dg0, dg1);
    step(0, 0, 0, 0, 0, 0, 1, 0, dg0, dg1);
    step(0, 0, 0, 0, 0, 0, 0, 0, dg0, dg1);
    #3;
    check("route_idle_busy", bus.busy_o, 0);

    // Full FIFO: no request while two are outstanding, even on the popping cycle.
    step(1, 32'h10, 0, 0, 1, 0, 0, $urandom, dg0, dg1);
    step(0, 0, 1, 32'h20, 1, 0, 0, $urandom, dg0, dg1);
    step(1, 32'h30, 1, 32'h24, 1, 0, 0, $urandom, dg0, dg1);
    step(1, 32'h30, 1, 32'h24, 1, 0, 1, $urandom, dg0, dg1);
    #3;
    check("full_pop_req", bus.instr_req_o, 0);
    step(1, 32'h30, 1, 32'h24, 1, 0, 0, $urandom, dg0, dg1);
    #3;
    check("full_next_req", bus.instr_req_o, 1);
    drain();

    // Randomised traffic; requesters hold req/addr until granted.
    p0p = 1'b0;
    p1p = 1'b0;
    p0a = '0;
    p1a = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0p && $urandom_range(0, 9) < 7) begin
        p0p = 1'b1;
        p0a = $urandom & 32'hFFFF_FFFC;
      end
      if (!p1p && $urandom_range(0, 9) < 4) begin
        p1p = 1'b1;
        p1a = $urandom & 32'hFFFF_FFFC;
      end
      step(p0p, p0a, p1p, p1a, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           (mem_q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom, dg0, dg1);
      if (dg0) p0p = 1'b0;
      if (dg1) p1p = 1'b0;
    end
    drain();

    // PMP-faulted grant is not tracked; the following rvalid is spurious.
    step(1, 32'h80, 0, 0, 1, 1, 0, $urandom, dg0, dg1);
    #3;
    check("pmp_err0", bus.p0_err_pmp_o, 1);
    step(0, 0, 0, 0, 0, 0, 1, $urandom, dg0, dg1);
    step(0, 0, 0, 0, 0, 0, 0, $urandom, dg0, dg1);
    #3;
    check("pmp_proto_err", bus.proto_err_o, 1);

    // Reset with one transaction in flight; its late response is then spurious.
    step(1, 32'h90, 0, 0, 1, 0, 0, $urandom, dg0, dg1);
    apply_reset("midrst");
    step(0, 0, 0, 0, 0, 0, 1, $urandom, dg0, dg1);
    step(0, 0, 0, 0, 0, 0, 0, $urandom, dg0, dg1);
    #3;
    check("midrst_proto_err", bus.proto_err_o, 1);

    @(negedge clk);
    check("rsp_left", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_instr_mem_arbiter.md
Name: riscv_instr_mem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: port 0 is the prefetch buffer, port 1 is the auxiliary fetcher for CFI/crypto metadata reads.
- Speaks the core's req/gnt/rvalid protocol on all sides. Responses are in order.
- Tracks the owner of each outstanding transaction and steers rvalid back to that owner.
- Fixed priority to port 0, with a starvation guard for port 1.

Parameters:
- RDATA_WIDTH, 32: width of the read data path.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions; also the owner-FIFO depth. Must be ≥1.
- STARVE_LIMIT, 8: number of consecutive cycles port 1 may wait with req high and no gnt before it takes priority. Must be ≥1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- p0_req_i, in, 1: port 0 request.
- p0_addr_i, in, 32: port 0 address.
- p0_gnt_o, out, 1: port 0 grant.
- p0_rvalid_o, out, 1: port 0 response valid.
- p0_err_pmp_o, out, 1: port 0 PMP error, qualifies p0_gnt_o.
- p1_req_i, in, 1: port 1 request.
- p1_addr_i, in, 32: port 1 address.
- p1_gnt_o, out, 1: port 1 grant.
- p1_rvalid_o, out, 1: port 1 response valid.
- p1_err_pmp_o, out, 1: port 1 PMP error, qualifies p1_gnt_o.
- rdata_o, out, RDATA_WIDTH: response data broadcast to both ports; valid only with the respective pX_rvalid_o.
- instr_req_o, out, 1: memory request.
- instr_addr_o, out, 32: memory address.
- instr_gnt_i, in, 1: memory grant.
- instr_rdata_i, in, RDATA_WIDTH: memory read data.
- instr_rvalid_i, in, 1: memory response valid.
- instr_err_pmp_i, in, 1: PMP fault, meaningful with instr_gnt_i.
- busy_o, out, 1: high when any transaction is outstanding or instr_req_o is high.
- proto_err_o, out, 1: sticky; set when instr_rvalid_i arrives with no transaction outstanding.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in ARB.
  - Owner FIFO empty, outstanding count 0.
  - Starvation counter 0, proto_err_o 0.
- FSM states:
  - ARB: select an owner combinationally.
  - LOCK0 / LOCK1: a request to memory is pending without gnt. Owner and address are frozen until instr_gnt_i (protocol: req/addr stable until gnt).
- Selection in ARB:
  - Port 1 is selected if p1_req_i and (starve_cnt == STARVE_LIMIT or !p0_req_i).
  - Otherwise port 0 is selected if p0_req_i.
  - Otherwise nothing is selected.
- Request forwarding:
  - instr_req_o = selected port's req AND count < MAX_OUTSTANDING.
  - instr_addr_o = selected port's address. When nothing is selected it is 0 (don't-care to memory).
  - When count == MAX_OUTSTANDING, instr_req_o is held low even if instr_rvalid_i pops in the same cycle.
- Grant:
  - pX_gnt_o = instr_gnt_i & instr_req_o & (owner == X), combinational, zero-latency.
  - pX_err_pmp_o = instr_err_pmp_i & pX_gnt_o.
- Locking:
  - ARB with instr_req_o=1 and instr_gnt_i=0 → LOCKx (x = selected owner).
  - LOCKx drives port x unconditionally. On instr_gnt_i → ARB.
  - A port-0 request arriving while in LOCK1 waits; no preemption.
- Owner FIFO and outstanding count:
  - On instr_gnt_i & !instr_err_pmp_i: push owner and increment count.
  - A PMP-faulted grant produces no rvalid and is not pushed.
  - On instr_rvalid_i with count > 0: pop, and raise pX_rvalid_o for the head owner in the same cycle (zero latency); rdata_o = instr_rdata_i.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - Read and write pointers wrap modulo MAX_OUTSTANDING.
- Spurious response: instr_rvalid_i with count == 0 → no pX_rvalid_o, FIFO unchanged, proto_err_o set to 1 until reset.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each cycle where p1_req_i=1 and p1_gnt_o=0.
  - Cleared to 0 on p1_gnt_o or when p1_req_i=0.
  - A port-1 request blocked only by a full FIFO still counts.
- Reset mid-operation: all state clears immediately, including the owner FIFO. Responses that arrive later for pre-reset transactions count as spurious.
- Widths: count is $clog2(MAX_OUTSTANDING+1) bits; starve_cnt is $clog2(STARVE_LIMIT+1) bits.

Test Plan:
- Arbitration: p0_req_i=1 and p1_req_i=1 in the same cycle, memory gnt always 1 → p0_gnt_o every cycle. p1_gnt_o goes high in the 9th cycle (starve_cnt reached 8), then starve_cnt=0 and port 0 wins again.
- Lock: port 1 alone, addr 0x100, instr_gnt_i=0 for 3 cycles, p0_req_i rises in cycle 2 → instr_addr_o stays 0x100 until gnt; port 0 is granted the following cycle.
- Response routing: grants in order P0 (0x0), P1 (0x200), then rvalids with data 0xA, 0xB → p0_rvalid_o with rdata 0xA, then p1_rvalid_o with rdata 0xB; count ends at 0.
- Full FIFO: two outstanding, both ports requesting → instr_req_o=0. With rvalid and p0_req_i high in the same cycle, instr_req_o=0 in that cycle and goes to 1 in the next.
- PMP fault: port 0 granted with instr_err_pmp_i=1 → p0_err_pmp_o=1, count stays 0. A following rvalid sets proto_err_o=1 and raises no pX_rvalid_o.
- Reset mid-operation: with one transaction outstanding, assert rst_n=0 → all outputs 0 and busy_o=0 after reset release.
